// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, flag indices and canonical NaN helper for the fp add/sub unit
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    PACK,
    HOLD
  } state_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic inexact;
  } fp_flags_t;

  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

  // Wide enough for any supported format; callers keep the low 1+exp_w+man_w bits.
  function automatic logic [127:0] canon_qnan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = (((128'd1 << exp_w) - 128'd1) << man_w) | (128'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter; all-zero input yields WIDTH
module fp_lzc #(
  parameter int WIDTH = 56
) (
  input  logic [WIDTH-1:0]         i_data,
  output logic [$clog2(WIDTH+1)-1:0] o_count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit determines the count last.
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_mc.sv
// rtl/fp_addsub_mc.sv - multicycle IEEE-754 add/subtract, RNE rounding, denormals, valid/ready
module fp_addsub_mc
  import fp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_z,
  output logic [2:0]             out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int MW   = MAN_W + 4;
  localparam int LW   = $clog2(MW + 1);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic [EW-1:0]        MW_E   = EW'(MW);
  localparam logic [127:0]         QNAN_WIDE = canon_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN   = QNAN_WIDE[W-1:0];
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;

  state_t                 r_state, w_state_nxt;
  logic [W-1:0]           r_a, r_b;
  logic                   r_sub;
  logic                   r_sa, r_sb, r_s;
  logic signed [EW-1:0]   r_ea, r_eb, r_e;
  logic [MW-1:0]          r_ma, r_mb, r_m;
  logic [MW:0]            r_sum;
  logic [MAN_W:0]         r_rm;
  logic                   r_inexact;
  logic                   r_special;
  logic [W-1:0]           r_spec_z;
  fp_flags_t              r_spec_flags;

  function automatic logic signed [EW-1:0] unpack_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EMIN_E : ($signed({2'b00, e}) - BIAS_E);
  endfunction

  // Unpack: b sign is flipped here so every later stage only sees addition.
  logic                 w_a_s, w_b_s;
  logic [EXP_W-1:0]     w_a_e, w_b_e;
  logic [MAN_W-1:0]     w_a_f, w_b_f;
  logic                 w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic                 w_special;
  logic [W-1:0]         w_spec_z;
  fp_flags_t            w_spec_flags;

  assign w_a_s    = r_a[W-1];
  assign w_b_s    = r_b[W-1] ^ r_sub;
  assign w_a_e    = r_a[W-2:MAN_W];
  assign w_b_e    = r_b[W-2:MAN_W];
  assign w_a_f    = r_a[MAN_W-1:0];
  assign w_b_f    = r_b[MAN_W-1:0];
  assign w_a_nan  = (w_a_e == EXP_ONES) && (w_a_f != '0);
  assign w_b_nan  = (w_b_e == EXP_ONES) && (w_b_f != '0);
  assign w_a_inf  = (w_a_e == EXP_ONES) && (w_a_f == '0);
  assign w_b_inf  = (w_b_e == EXP_ONES) && (w_b_f == '0);
  assign w_a_zero = (w_a_e == '0) && (w_a_f == '0);
  assign w_b_zero = (w_b_e == '0) && (w_b_f == '0);

  always_comb begin
    w_special    = 1'b1;
    w_spec_z     = '0;
    w_spec_flags = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_s != w_b_s))) begin
      w_spec_z             = QNAN;
      w_spec_flags.invalid = 1'b1;
    end else if (w_a_inf) begin
      w_spec_z = {w_a_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec_z = {w_b_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_a_zero && w_b_zero) begin
      w_spec_z = {w_a_s & w_b_s, {(W-1){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  // Align: sticky collects every bit pushed past the low end.
  logic                 w_a_ge;
  logic [EW-1:0]        w_d;
  logic [MW-1:0]        w_small, w_mask, w_shifted;

  assign w_a_ge    = (r_ea >= r_eb);
  assign w_d       = w_a_ge ? (r_ea - r_eb) : (r_eb - r_ea);
  assign w_small   = w_a_ge ? r_mb : r_ma;
  assign w_mask    = ~({MW{1'b1}} << w_d);
  assign w_shifted = (w_d >= MW_E) ? {{(MW-1){1'b0}}, |w_small}
                                   : ((w_small >> w_d) | {{(MW-1){1'b0}}, |(w_small & w_mask)});

  logic [MW:0]          w_sum;
  logic                 w_sum_s;

  always_comb begin
    w_sum   = '0;
    w_sum_s = 1'b0;
    if (r_sa == r_sb) begin
      w_sum   = {1'b0, r_ma} + {1'b0, r_mb};
      w_sum_s = r_sa;
    end else if (r_ma >= r_mb) begin
      w_sum   = {1'b0, r_ma} - {1'b0, r_mb};
      w_sum_s = r_sa;
    end else begin
      w_sum   = {1'b0, r_mb} - {1'b0, r_ma};
      w_sum_s = r_sb;
    end
    if (w_sum == '0) w_sum_s = 1'b0;
  end

  // Normalise: left shift is limited by headroom above the minimum exponent.
  logic [LW-1:0]        w_lzc;
  logic [EW-1:0]        w_room, w_lz_e, w_shift;
  logic [MW-1:0]        w_norm_m;
  logic signed [EW-1:0] w_norm_e;

  fp_lzc #(.WIDTH(MW)) u_lzc (
    .i_data  (r_sum[MW-1:0]),
    .o_count (w_lzc)
  );

  assign w_room  = r_e - EMIN_E;
  assign w_lz_e  = {{(EW-LW){1'b0}}, w_lzc};
  assign w_shift = (w_lz_e > w_room) ? w_room : w_lz_e;

  always_comb begin
    if (r_sum[MW]) begin
      w_norm_m = {r_sum[MW:2], r_sum[1] | r_sum[0]};
      w_norm_e = r_e + ONE_E;
    end else begin
      w_norm_m = r_sum[MW-1:0] << w_shift;
      w_norm_e = r_e - w_shift;
    end
  end

  logic                 w_inc;
  logic [MAN_W+1:0]     w_rnd;
  logic [MAN_W:0]       w_rnd_m;
  logic signed [EW-1:0] w_rnd_e;

  assign w_inc   = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
  assign w_rnd   = {1'b0, r_m[MW-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};
  assign w_rnd_m = w_rnd[MAN_W+1] ? w_rnd[MAN_W+1:1] : w_rnd[MAN_W:0];
  assign w_rnd_e = w_rnd[MAN_W+1] ? (r_e + ONE_E) : r_e;

  logic signed [EW-1:0] w_ebias;
  logic [EXP_W-1:0]     w_exp_field;
  logic [W-1:0]         w_pack_z;
  fp_flags_t            w_pack_flags;

  assign w_ebias     = r_e + BIAS_E;
  assign w_exp_field = r_rm[MAN_W] ? w_ebias[EXP_W-1:0] : '0;

  always_comb begin
    w_pack_flags = '0;
    if (r_special) begin
      w_pack_z     = r_spec_z;
      w_pack_flags = r_spec_flags;
    end else if (r_e > BIAS_E) begin
      w_pack_z              = {r_s, EXP_ONES, {MAN_W{1'b0}}};
      w_pack_flags.overflow = 1'b1;
      w_pack_flags.inexact  = 1'b1;
    end else begin
      w_pack_z             = {r_s, w_exp_field, r_rm[MAN_W-1:0]};
      w_pack_flags.inexact = r_inexact;
    end
  end

  // Specials skip the arithmetic stages but still leave through PACK.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = UNPACK;
      UNPACK:  w_state_nxt = w_special ? PACK : ALIGN;
      ALIGN:   w_state_nxt = ADD;
      ADD:     w_state_nxt = NORM;
      NORM:    w_state_nxt = ROUND;
      ROUND:   w_state_nxt = PACK;
      PACK:    w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready = (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (in_valid) begin
          r_a   <= in_a;
          r_b   <= in_b;
          r_sub <= in_sub;
        end
        UNPACK: begin
          r_special    <= w_special;
          r_spec_z     <= w_spec_z;
          r_spec_flags <= w_spec_flags;
          r_sa         <= w_a_s;
          r_sb         <= w_b_s;
          r_ea         <= unpack_exp(w_a_e);
          r_eb         <= unpack_exp(w_b_e);
          r_ma         <= {w_a_e != '0, w_a_f, 3'b000};
          r_mb         <= {w_b_e != '0, w_b_f, 3'b000};
        end
        ALIGN: begin
          if (w_a_ge) r_mb <= w_shifted;
          else        r_ma <= w_shifted;
          r_e <= w_a_ge ? r_ea : r_eb;
        end
        ADD: begin
          r_sum <= w_sum;
          r_s   <= w_sum_s;
        end
        NORM: begin
          r_m <= w_norm_m;
          r_e <= w_norm_e;
        end
        ROUND: begin
          r_rm      <= w_rnd_m;
          r_e       <= w_rnd_e;
          r_inexact <= |r_m[2:0];
        end
        PACK: begin
          out_z     <= w_pack_z;
          out_flags <= w_pack_flags;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_mc.sv
// tb/tb_fp_addsub_mc.sv - directed self-checking bench for fp_addsub_mc and fp_lzc
module tb_fp_addsub_mc;
  import fp_pkg::*;

  logic        clk, reset;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [63:0] in_a, in_b, out_z;
  logic [2:0]  out_flags;

  logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
  logic [15:0] h_in_a, h_in_b, h_out_z;
  logic [2:0]  h_out_flags;

  logic [7:0]  lzc_in;
  logic [3:0]  lzc_cnt;

  int errors = 0;
  int checks = 0;

  fp_addsub_mc #(.EXP_W(11), .MAN_W(52)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags)
  );

  fp_addsub_mc #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_sub(h_in_sub), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .out_z(h_out_z), .out_flags(h_out_flags)
  );

  fp_lzc #(.WIDTH(8)) u_lzc (.i_data(lzc_in), .o_count(lzc_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one operation, waits (bounded) for the result, then consumes it.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                       output logic [63:0] z, output logic [2:0] f, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    z = out_z;
    f = out_flags;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_z !== 64'h0) begin errors++; $display("FAIL reset_out_z: got %h want 0", out_z); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", out_flags); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (h_out_valid !== 1'b0 || h_in_ready !== 1'b1) begin errors++; $display("FAIL reset_half: got valid=%b ready=%b want 0/1", h_out_valid, h_in_ready); end
  endtask

  task automatic test_add;
    logic [63:0] z; logic [2:0] f; int lat;
    do_op(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, z, f, lat);
    checks++; if (z !== 64'h4008000000000000) begin errors++; $display("FAIL add_1p2_z: got %h want 4008000000000000", z); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL add_1p2_flags: got %b want 000", f); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL add_1p2_latency: got %0d want 6", lat); end
  endtask

  task automatic test_zero;
    logic [63:0] z; logic [2:0] f; int lat;
    do_op(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, z, f, lat);
    checks++; if (z !== 64'h0) begin errors++; $display("FAIL sub_1m1_z: got %h want 0000000000000000", z); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL sub_1m1_flags: got %b want 000", f); end
    do_op(64'h8000000000000000, 64'h8000000000000000, 1'b0, z, f, lat);
    checks++; if (z !== 64'h8000000000000000) begin errors++; $display("FAIL negzero_z: got %h want 8000000000000000", z); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL negzero_flags: got %b want 000", f); end
  endtask

  task automatic test_special;
    logic [63:0] z; logic [2:0] f; int lat;
    do_op(64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0, z, f, lat);
    checks++; if (z !== 64'h7FF8000000000000) begin errors++; $display("FAIL inf_minus_inf_z: got %h want 7FF8000000000000", z); end
    checks++; if (f[FLAG_INVALID] !== 1'b1 || f !== 3'b100) begin errors++; $display("FAIL inf_minus_inf_flags: got %b want 100", f); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL inf_minus_inf_latency: got %0d want 2", lat); end
  endtask

  task automatic test_overflow;
    logic [63:0] z; logic [2:0] f; int lat;
    do_op(64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, z, f, lat);
    checks++; if (z !== 64'h7FF0000000000000) begin errors++; $display("FAIL overflow_z: got %h want 7FF0000000000000", z); end
    checks++; if (f[FLAG_OVERFLOW] !== 1'b1 || f !== 3'b011) begin errors++; $display("FAIL overflow_flags: got %b want 011", f); end
  endtask

  task automatic test_round_denorm;
    logic [63:0] z; logic [2:0] f; int lat;
    do_op(64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, z, f, lat);
    checks++; if (z !== 64'h3FF0000000000000) begin errors++; $display("FAIL rne_tie_even_z: got %h want 3FF0000000000000", z); end
    checks++; if (f[FLAG_INEXACT] !== 1'b1 || f !== 3'b001) begin errors++; $display("FAIL rne_tie_even_flags: got %b want 001", f); end
    do_op(64'h0000000000000001, 64'h0000000000000001, 1'b0, z, f, lat);
    checks++; if (z !== 64'h0000000000000002) begin errors++; $display("FAIL denorm_add_z: got %h want 0000000000000002", z); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL denorm_add_flags: got %b want 000", f); end
  endtask

  task automatic test_half;
    int lat;
    @(negedge clk);
    h_in_a = 16'h3C00; h_in_b = 16'h3C00; h_in_sub = 1'b0; h_in_valid = 1'b1;
    @(posedge clk);
    #1 h_in_valid = 1'b0;
    lat = 0;
    while (!h_out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    checks++; if (h_out_z !== 16'h4000) begin errors++; $display("FAIL half_1p1_z: got %h want 4000", h_out_z); end
    checks++; if (h_out_flags !== 3'b000) begin errors++; $display("FAIL half_1p1_flags: got %b want 000", h_out_flags); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL half_1p1_latency: got %0d want 6", lat); end
    @(negedge clk) h_out_ready = 1'b1;
    @(posedge clk);
    #1 h_out_ready = 1'b0;
  endtask

  task automatic test_hold;
    int lat;
    @(negedge clk);
    in_a = 64'h3FF0000000000000; in_b = 64'h4000000000000000; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_seen: got %b want 1", out_valid); end
    // New operands offered while busy must not disturb the held result.
    in_a = 64'h4008000000000000; in_b = 64'h4008000000000000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_z !== 64'h4008000000000000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got z=%h ready=%b valid=%b want 4008000000000000/0/1", i, out_z, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    in_a = 64'h3FF0000000000000; in_b = 64'h4000000000000000; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_state: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_result: got out_valid seen=%b want 0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] z; logic [2:0] f; int lat;
    do_op(64'h4008000000000000, 64'h3FF0000000000000, 1'b1, z, f, lat);
    checks++; if (z !== 64'h4000000000000000 || f !== 3'b000) begin errors++; $display("FAIL b2b_3m1: got %h/%b want 4000000000000000/000", z, f); end
    do_op(64'hBFF0000000000000, 64'h3FE0000000000000, 1'b0, z, f, lat);
    checks++; if (z !== 64'hBFE0000000000000 || f !== 3'b000) begin errors++; $display("FAIL b2b_neg1p0p5: got %h/%b want BFE0000000000000/000", z, f); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_latency: got %0d want 6", lat); end
  endtask

  task automatic test_lzc;
    logic [7:0] vin [4];
    logic [3:0] vexp [4];
    vin[0] = 8'h00; vexp[0] = 4'd8;
    vin[1] = 8'h80; vexp[1] = 4'd0;
    vin[2] = 8'h01; vexp[2] = 4'd7;
    vin[3] = 8'h13; vexp[3] = 4'd3;
    for (int i = 0; i < 4; i++) begin
      lzc_in = vin[i];
      #1;
      checks++; if (lzc_cnt !== vexp[i]) begin errors++; $display("FAIL lzc[%h]: got %0d want %0d", vin[i], lzc_cnt, vexp[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    h_in_valid = 1'b0; h_in_sub = 1'b0; h_out_ready = 1'b0; h_in_a = '0; h_in_b = '0;
    lzc_in = '0;
    test_reset;
    test_add;
    test_zero;
    test_special;
    test_overflow;
    test_round_denorm;
    test_half;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    test_lzc;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
